// File: rtl/audio_input_analyzer_if.sv
// CODEC ADC read handshake: sample pair presented with read_ready, popped by a one-cycle read strobe.
// master is the analyzer pulling samples, slave is the CODEC side.
interface audio_input_analyzer_if;
  logic        read_ready;
  logic [23:0] readdata_left;
  logic [23:0] readdata_right;
  logic        read;

  modport master (input read_ready, readdata_left, readdata_right, output read);
  modport slave  (output read_ready, readdata_left, readdata_right, input read);
endinterface

// File: rtl/audio_input_analyzer.sv
// Pulls stereo ADC pairs, mixes to mono, reports peak |mono| and hysteresis zero crossings per 2^WINDOW_LOG2 samples.
// One sample per 3 cycles max (IDLE/ACK/PROC); results update one cycle after the window's last PROC; CODEC stalls simply hold IDLE.
module audio_input_analyzer #(
  parameter int          WINDOW_LOG2 = 10,
  parameter logic [23:0] HYST        = 24'h000400
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   enable,
  audio_input_analyzer_if.master codec,
  output logic [22:0]            peak,
  output logic [WINDOW_LOG2:0]   zero_crossings,
  output logic                   result_valid
);

  typedef enum logic [1:0] {IDLE, ACK, PROC} state_t;

  localparam logic signed [23:0] HYST_P = HYST;
  localparam logic signed [23:0] HYST_N = -HYST_P;

  state_t                   state;
  logic signed [23:0]       l_q;
  logic signed [23:0]       r_q;
  logic [WINDOW_LOG2-1:0]   sample_cnt;
  logic [22:0]              run_peak;
  logic [WINDOW_LOG2:0]     run_cross;
  logic                     sign_state;
  logic                     sign_valid;

  logic signed [23:0]       mono;
  logic signed [23:0]       neg_mono;
  logic [22:0]              mag;
  logic [22:0]              peak_next;
  logic                     above;
  logic                     below;
  logic                     crossed;
  logic [WINDOW_LOG2:0]     cross_next;

  always_comb begin
    // Halving each channel first keeps the sum inside 24 bits.
    mono     = (l_q >>> 1) + (r_q >>> 1);
    neg_mono = -mono;
    if (mono == 24'sh800000)
      mag = 23'h7FFFFF;
    else if (mono[23])
      mag = neg_mono[22:0];
    else
      mag = mono[22:0];
    peak_next  = (mag > run_peak) ? mag : run_peak;
    above      = mono > HYST_P;
    below      = mono < HYST_N;
    crossed    = sign_valid && ((above && !sign_state) || (below && sign_state));
    cross_next = run_cross + {{WINDOW_LOG2{1'b0}}, crossed};
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state          <= IDLE;
      codec.read     <= 1'b0;
      l_q            <= '0;
      r_q            <= '0;
      sample_cnt     <= '0;
      run_peak       <= '0;
      run_cross      <= '0;
      sign_state     <= 1'b0;
      sign_valid     <= 1'b0;
      peak           <= '0;
      zero_crossings <= '0;
      result_valid   <= 1'b0;
    end else begin
      result_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (enable && codec.read_ready) begin
            codec.read <= 1'b1;
            l_q        <= $signed(codec.readdata_left);
            r_q        <= $signed(codec.readdata_right);
            state      <= ACK;
          end
        end
        ACK: begin
          codec.read <= 1'b0;
          state      <= PROC;
        end
        PROC: begin
          sample_cnt <= sample_cnt + 1'b1;
          if (above) begin
            sign_state <= 1'b1;
            sign_valid <= 1'b1;
          end else if (below) begin
            sign_state <= 1'b0;
            sign_valid <= 1'b1;
          end
          // Sign history deliberately survives the window boundary.
          if (&sample_cnt) begin
            peak           <= peak_next;
            zero_crossings <= cross_next;
            result_valid   <= 1'b1;
            run_peak       <= '0;
            run_cross      <= '0;
          end else begin
            run_peak  <= peak_next;
            run_cross <= cross_next;
          end
          state <= IDLE;
        end
        default: begin
          codec.read <= 1'b0;
          state      <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_audio_input_analyzer.sv
// Bench for audio_input_analyzer with a queue-backed CODEC model and a per-window reference model.
module tb_audio_input_analyzer;
  localparam int          W    = 4;
  localparam int          N    = 1 << W;
  localparam logic [23:0] HYST = 24'h000400;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic [22:0] peak;
  logic [W:0]  zero_crossings;
  logic        result_valid;

  audio_input_analyzer_if codec();

  audio_input_analyzer #(.WINDOW_LOG2(W), .HYST(HYST)) dut (
    .clock          (clock),
    .reset          (reset),
    .enable         (enable),
    .codec          (codec.master),
    .peak           (peak),
    .zero_crossings (zero_crossings),
    .result_valid   (result_valid)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int passes = 0;
  logic [23:0] q_l[$], q_r[$];
  logic [23:0] st_l[$], st_r[$];
  int m_sign = -1;

  // CODEC: presents queue head, pops it when a read strobe is seen.
  initial begin
    codec.read_ready     = 1'b0;
    codec.readdata_left  = '0;
    codec.readdata_right = '0;
    forever begin
      @(negedge clock);
      if (codec.read === 1'b1 && q_l.size() > 0) begin
        void'(q_l.pop_front());
        void'(q_r.pop_front());
      end
      if (q_l.size() > 0) begin
        codec.read_ready     = 1'b1;
        codec.readdata_left  = q_l[0];
        codec.readdata_right = q_r[0];
      end else begin
        codec.read_ready = 1'b0;
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic int mono_of(logic [23:0] l, logic [23:0] r);
    int li, ri;
    li = int'($signed(l));
    ri = int'($signed(r));
    return (li >>> 1) + (ri >>> 1);
  endfunction

  task automatic model_window(output int exp_peak, output int exp_zc);
    int m, a;
    exp_peak = 0;
    exp_zc   = 0;
    foreach (st_l[i]) begin
      m = mono_of(st_l[i], st_r[i]);
      a = (m < 0) ? -m : m;
      if (a > 32'h7FFFFF) a = 32'h7FFFFF;
      if (a > exp_peak) exp_peak = a;
      if (m > int'(HYST)) begin
        if (m_sign == 0) exp_zc++;
        m_sign = 1;
      end else if (m < -int'(HYST)) begin
        if (m_sign == 1) exp_zc++;
        m_sign = 0;
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    repeat (2) @(negedge clock);
    reset  = 1'b0;
    m_sign = -1;
  endtask

  task automatic run_window(input string name, input bit chk_zero);
    int  exp_peak, exp_zc, cyc;
    bit  seen_read, got, nonzero;
    model_window(exp_peak, exp_zc);
    foreach (st_l[i]) begin
      q_l.push_back(st_l[i]);
      q_r.push_back(st_r[i]);
    end
    st_l.delete();
    st_r.delete();
    enable    = 1'b1;
    seen_read = 1'b0;
    got       = 1'b0;
    nonzero   = 1'b0;
    cyc       = 0;
    for (int c = 0; c < 400 && !got; c++) begin
      @(negedge clock);
      if (codec.read === 1'b1 && !seen_read) begin
        seen_read = 1'b1;
        cyc       = 0;
      end else if (seen_read) begin
        cyc++;
      end
      if (result_valid === 1'b1) got = 1'b1;
      else if (peak !== 23'd0 || zero_crossings !== '0) nonzero = 1'b1;
    end
    checks++;
    if (!got) $display("FAIL %s result_valid timeout: got none, required one pulse", name);
    else passes++;
    checks++;
    if (cyc !== 47) $display("FAIL %s latency: got %0d cycles from first read, required 47", name, cyc);
    else passes++;
    checks++;
    if (peak !== exp_peak[22:0]) $display("FAIL %s peak: got %h, required %h", name, peak, exp_peak[22:0]);
    else passes++;
    checks++;
    if (zero_crossings !== exp_zc[W:0]) $display("FAIL %s zero_crossings: got %0d, required %0d", name, zero_crossings, exp_zc);
    else passes++;
    if (chk_zero) begin
      checks++;
      if (nonzero) $display("FAIL %s outputs before window end: got nonzero, required 0", name);
      else passes++;
    end
    @(negedge clock);
    checks++;
    if (result_valid !== 1'b0) $display("FAIL %s pulse width: got result_valid=%b after pulse, required 0", name, result_valid);
    else passes++;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 40; i++) begin
      q_l.push_back(24'($urandom));
      q_r.push_back(24'($urandom));
    end
    enable = 1'b1;
    @(negedge clock);
    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clock);
      checks++;
      if (codec.read !== 1'b0 || peak !== 23'd0 || zero_crossings !== '0 || result_valid !== 1'b0)
        $display("FAIL reset_outputs: got read=%b peak=%h zc=%0d rv=%b, required all 0",
                 codec.read, peak, zero_crossings, result_valid);
      else passes++;
    end
    reset  = 1'b0;
    m_sign = -1;
    @(negedge clock);
    checks++;
    if (codec.read !== 1'b1) $display("FAIL first_read: got read=%b one cycle after reset, required 1", codec.read);
    else passes++;
  endtask

  task automatic test_throughput();
    int cnt, last, seen;
    bit bad_gap;
    cnt = 0; last = 0; bad_gap = 0;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clock);
      if (codec.read === 1'b1) begin
        cnt++;
        if (i - last != 3) bad_gap = 1'b1;
        last = i;
      end
    end
    checks++;
    if (cnt !== 10) $display("FAIL throughput_count: got %0d reads in 30 cycles, required 10", cnt);
    else passes++;
    checks++;
    if (bad_gap) $display("FAIL throughput_spacing: got uneven read spacing, required every 3rd cycle");
    else passes++;
    seen = 0;
    for (int i = 0; i < 5 && seen == 0; i++) begin
      @(negedge clock);
      if (codec.read === 1'b1) seen = 1;
    end
    enable = 1'b0;
    cnt = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clock);
      if (codec.read === 1'b1) cnt++;
    end
    checks++;
    if (seen != 1 || cnt !== 0) $display("FAIL enable_stop: got %0d reads after disable (strobe seen=%0d), required 0", cnt, seen);
    else passes++;
    q_l.delete();
    q_r.delete();
  endtask

  task automatic test_peak();
    do_reset();
    for (int i = 0; i < N; i++) begin
      st_l.push_back(24'h100000);
      st_r.push_back(24'h100000);
    end
    run_window("peak_const", 1'b0);
  endtask

  task automatic test_crossings();
    do_reset();
    for (int w = 0; w < 2; w++) begin
      for (int i = 0; i < N; i++) begin
        st_l.push_back((i % 2 == 0) ? 24'h010000 : 24'hFF0000);
        st_r.push_back((i % 2 == 0) ? 24'h010000 : 24'hFF0000);
      end
      run_window((w == 0) ? "cross_first" : "cross_carry", 1'b0);
    end
  endtask

  task automatic test_hysteresis();
    do_reset();
    for (int i = 0; i < N; i++) begin
      st_l.push_back((i % 2 == 0) ? 24'h000300 : 24'hFFFD00);
      st_r.push_back((i % 2 == 0) ? 24'h000300 : 24'hFFFD00);
    end
    run_window("hyst_band", 1'b0);
    for (int i = 0; i < N; i++) begin
      st_l.push_back(24'h800000);
      st_r.push_back(24'h800000);
    end
    run_window("saturate", 1'b0);
  endtask

  task automatic test_reset_mid_window();
    do_reset();
    for (int i = 0; i < 7; i++) begin
      q_l.push_back(24'($urandom));
      q_r.push_back(24'($urandom));
    end
    enable = 1'b1;
    for (int i = 0; i < 100 && q_l.size() > 0; i++) @(negedge clock);
    repeat (4) @(negedge clock);
    enable = 1'b0;
    do_reset();
    for (int i = 0; i < N; i++) begin
      st_l.push_back(24'($urandom));
      st_r.push_back(24'($urandom));
    end
    run_window("reset_mid_window", 1'b1);
  endtask

  task automatic test_random();
    int v;
    do_reset();
    for (int w = 0; w < 3; w++) begin
      for (int i = 0; i < N; i++) begin
        for (int ch = 0; ch < 2; ch++) begin
          case ($urandom_range(0, 2))
            0:       v = int'($urandom_range(0, 32'h1800)) - 32'hC00;
            1:       v = int'($urandom);
            default: v = $urandom_range(0, 1) ? 32'h800000 : 32'h7FFFFF;
          endcase
          if (ch == 0) st_l.push_back(v[23:0]);
          else         st_r.push_back(v[23:0]);
        end
      end
      run_window("random_window", 1'b0);
    end
  endtask

  initial begin
    test_reset();
    test_throughput();
    test_peak();
    test_crossings();
    test_hysteresis();
    test_reset_mid_window();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
